// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Brief    : Writeback result select, 32-entry register file with write-through
//            bypass on both decode read ports, and a committed-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int PC_W     = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_W,
    input  logic              mem_to_reg_W,
    input  logic [DATA_W-1:0] read_data_W,
    input  logic [DATA_W-1:0] alu_out_W,
    input  logic [REG_AW-1:0] write_reg_W,
    input  logic [PC_W-1:0]   addressP1_WB,
    input  logic              jump_W,
    input  logic [REG_AW-1:0] rs_addr_D,
    input  logic [REG_AW-1:0] rt_addr_D,
    output logic [DATA_W-1:0] rs_data_D,
    output logic [DATA_W-1:0] rt_data_D,
    output logic [DATA_W-1:0] result_W,
    output logic [REG_AW-1:0] wb_dest_W,
    output logic              wb_en_W,
    output logic [31:0]       wb_count
);

    localparam int          c_NREGS = 2 ** REG_AW;
    localparam [REG_AW-1:0] c_LINK  = REG_AW'(LINK_REG);

    logic [DATA_W-1:0] r_regs [0:c_NREGS-1];
    logic [31:0]       r_wb_count;

    logic [DATA_W-1:0] w_result;
    logic [REG_AW-1:0] w_dest;
    logic              w_en;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Jump-and-link overrides both the data source and the destination.
    always_comb begin
        w_result = alu_out_W;
        w_dest   = write_reg_W;
        if (jump_W) begin
            w_result = {{(DATA_W-PC_W){1'b0}}, addressP1_WB};
            w_dest   = c_LINK;
        end else if (mem_to_reg_W) begin
            w_result = read_data_W;
        end
        w_en = reg_write_W & (w_dest != '0) & ~reset;
    end

    // w_en already excludes r0, so the bypass can never leak a value into r0.
    always_comb begin
        w_rs_data = r_regs[rs_addr_D];
        if (rs_addr_D == '0) begin
            w_rs_data = '0;
        end else if (w_en && (rs_addr_D == w_dest)) begin
            w_rs_data = w_result;
        end
        w_rt_data = r_regs[rt_addr_D];
        if (rt_addr_D == '0) begin
            w_rt_data = '0;
        end else if (w_en && (rt_addr_D == w_dest)) begin
            w_rt_data = w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_en) begin
            r_regs[w_dest] <= w_result;
            r_wb_count     <= r_wb_count + 32'd1;
        end
    end

    assign result_W  = w_result;
    assign wb_dest_W = w_dest;
    assign wb_en_W   = w_en;
    assign rs_data_D = w_rs_data;
    assign rt_data_D = w_rt_data;
    assign wb_count  = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Brief    : Directed self-checking bench for writeback_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic        reg_write_W;
    logic        mem_to_reg_W;
    logic [31:0] read_data_W;
    logic [31:0] alu_out_W;
    logic [4:0]  write_reg_W;
    logic [4:0]  addressP1_WB;
    logic        jump_W;
    logic [4:0]  rs_addr_D;
    logic [4:0]  rt_addr_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;
    logic [31:0] result_W;
    logic [4:0]  wb_dest_W;
    logic        wb_en_W;
    logic [31:0] wb_count;

    int n_checks;
    int n_errors;

    writeback_regfile #(
        .DATA_W  (32),
        .REG_AW  (5),
        .PC_W    (5),
        .LINK_REG(31)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write_W (reg_write_W),
        .mem_to_reg_W(mem_to_reg_W),
        .read_data_W (read_data_W),
        .alu_out_W   (alu_out_W),
        .write_reg_W (write_reg_W),
        .addressP1_WB(addressP1_WB),
        .jump_W      (jump_W),
        .rs_addr_D   (rs_addr_D),
        .rt_addr_D   (rt_addr_D),
        .rs_data_D   (rs_data_D),
        .rt_data_D   (rt_data_D),
        .result_W    (result_W),
        .wb_dest_W   (wb_dest_W),
        .wb_en_W     (wb_en_W),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        reset        = 1'b0;
        reg_write_W  = 1'b0;
        mem_to_reg_W = 1'b0;
        read_data_W  = '0;
        alu_out_W    = '0;
        write_reg_W  = '0;
        addressP1_WB = '0;
        jump_W       = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; this advances one edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs_addr_D = '0;
        rt_addr_D = '0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (wb_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_count: got %h expected %h", wb_count, 32'd0);
        end
        n_checks++;
        if (result_W !== 32'd0 || wb_dest_W !== 5'd0 || wb_en_W !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got result=%h dest=%0d en=%b expected 0/0/0",
                     result_W, wb_dest_W, wb_en_W);
        end
        for (int a = 0; a < 32; a++) begin
            rs_addr_D = 5'(a);
            rt_addr_D = 5'(31 - a);
            #1;
            n_checks++;
            if (rs_data_D !== 32'd0 || rt_data_D !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_read[%0d]: got rs=%h rt=%h expected 0", a, rs_data_D, rt_data_D);
            end
        end
    endtask

    task automatic test_alu_write();
        idle_inputs();
        reg_write_W = 1'b1;
        alu_out_W   = 32'h0000_1234;
        read_data_W = 32'hFFFF_0000;
        write_reg_W = 5'd8;
        rs_addr_D   = 5'd8;
        rt_addr_D   = 5'd7;
        #1;
        n_checks++;
        if (rs_data_D !== 32'h1234 || wb_en_W !== 1'b1 || result_W !== 32'h1234) begin
            n_errors++;
            $display("FAIL alu_bypass: got rs=%h en=%b result=%h expected 1234/1/1234",
                     rs_data_D, wb_en_W, result_W);
        end
        n_checks++;
        if (rt_data_D !== 32'd0) begin
            n_errors++;
            $display("FAIL alu_other_port: got %h expected %h", rt_data_D, 32'd0);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data_D !== 32'h1234 || wb_count !== 32'd1) begin
            n_errors++;
            $display("FAIL alu_commit: got r8=%h count=%0d expected 1234/1", rs_data_D, wb_count);
        end
    endtask

    task automatic test_load_write();
        idle_inputs();
        reg_write_W  = 1'b1;
        mem_to_reg_W = 1'b1;
        read_data_W  = 32'hDEAD_BEEF;
        alu_out_W    = 32'h5;
        write_reg_W  = 5'd3;
        #1;
        n_checks++;
        if (result_W !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL load_select: got %h expected %h", result_W, 32'hDEAD_BEEF);
        end
        step();
        // r0 write attempt: no enable, no bypass, no count.
        idle_inputs();
        reg_write_W = 1'b1;
        alu_out_W   = 32'hFFFF_FFFF;
        write_reg_W = 5'd0;
        rs_addr_D   = 5'd0;
        rt_addr_D   = 5'd3;
        #1;
        n_checks++;
        if (wb_en_W !== 1'b0 || rs_data_D !== 32'd0) begin
            n_errors++;
            $display("FAIL r0_bypass: got en=%b rs=%h expected 0/0", wb_en_W, rs_data_D);
        end
        n_checks++;
        if (rt_data_D !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL load_commit: got %h expected %h", rt_data_D, 32'hDEAD_BEEF);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data_D !== 32'd0 || wb_count !== 32'd2) begin
            n_errors++;
            $display("FAIL r0_write: got r0=%h count=%0d expected 0/2", rs_data_D, wb_count);
        end
        // Enable low must neither commit nor count.
        reg_write_W = 1'b0;
        alu_out_W   = 32'h9999;
        write_reg_W = 5'd3;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rt_data_D !== 32'hDEAD_BEEF || wb_count !== 32'd2) begin
            n_errors++;
            $display("FAIL bubble: got r3=%h count=%0d expected deadbeef/2", rt_data_D, wb_count);
        end
    endtask

    task automatic test_jump_link();
        idle_inputs();
        reg_write_W  = 1'b1;
        jump_W       = 1'b1;
        mem_to_reg_W = 1'b1;
        read_data_W  = 32'hAAAA_AAAA;
        alu_out_W    = 32'h5555_5555;
        addressP1_WB = 5'd17;
        write_reg_W  = 5'd4;
        rs_addr_D    = 5'd31;
        rt_addr_D    = 5'd4;
        #1;
        n_checks++;
        if (result_W !== 32'h11 || wb_dest_W !== 5'd31 || wb_en_W !== 1'b1) begin
            n_errors++;
            $display("FAIL jal_select: got result=%h dest=%0d en=%b expected 11/31/1",
                     result_W, wb_dest_W, wb_en_W);
        end
        n_checks++;
        if (rs_data_D !== 32'h11 || rt_data_D !== 32'd0) begin
            n_errors++;
            $display("FAIL jal_bypass: got rs=%h rt=%h expected 11/0", rs_data_D, rt_data_D);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data_D !== 32'h11 || rt_data_D !== 32'd0 || wb_count !== 32'd3) begin
            n_errors++;
            $display("FAIL jal_commit: got r31=%h r4=%h count=%0d expected 11/0/3",
                     rs_data_D, rt_data_D, wb_count);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        reg_write_W = 1'b1;
        write_reg_W = 5'd9;
        alu_out_W   = 32'hA;
        rs_addr_D   = 5'd9;
        rt_addr_D   = 5'd9;
        #1;
        n_checks++;
        if (rt_data_D !== 32'hA || rs_data_D !== 32'hA) begin
            n_errors++;
            $display("FAIL b2b_first: got rt=%h rs=%h expected a/a", rt_data_D, rs_data_D);
        end
        step();
        alu_out_W = 32'hB;
        #1;
        n_checks++;
        if (rt_data_D !== 32'hB || rs_data_D !== 32'hB) begin
            n_errors++;
            $display("FAIL b2b_second: got rt=%h rs=%h expected b/b", rt_data_D, rs_data_D);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rt_data_D !== 32'hB || wb_count !== 32'd5) begin
            n_errors++;
            $display("FAIL b2b_commit: got r9=%h count=%0d expected b/5", rt_data_D, wb_count);
        end
    endtask

    task automatic test_reset_collision();
        idle_inputs();
        reset       = 1'b1;
        reg_write_W = 1'b1;
        alu_out_W   = 32'h77;
        write_reg_W = 5'd10;
        rs_addr_D   = 5'd10;
        rt_addr_D   = 5'd9;
        #1;
        n_checks++;
        if (wb_en_W !== 1'b0 || rs_data_D !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_no_bypass: got en=%b rs=%h expected 0/0", wb_en_W, rs_data_D);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data_D !== 32'd0 || rt_data_D !== 32'd0 || wb_count !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_clear: got r10=%h r9=%h count=%0d expected 0/0/0",
                     rs_data_D, rt_data_D, wb_count);
        end
        reg_write_W = 1'b1;
        alu_out_W   = 32'h55;
        write_reg_W = 5'd10;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data_D !== 32'h55 || wb_count !== 32'd1) begin
            n_errors++;
            $display("FAIL rst_resume: got r10=%h count=%0d expected 55/1", rs_data_D, wb_count);
        end
    endtask

    task automatic test_counter_wrap();
        idle_inputs();
        dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (wb_count !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL wrap_deposit: got %h expected %h", wb_count, 32'hFFFF_FFFF);
        end
        reg_write_W = 1'b1;
        alu_out_W   = 32'h1;
        write_reg_W = 5'd12;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (wb_count !== 32'd0) begin
            n_errors++;
            $display("FAIL wrap_count: got %h expected %h", wb_count, 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rs_addr_D = '0;
        rt_addr_D = '0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_write();
        test_jump_link();
        test_back_to_back();
        test_reset_collision();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage plus architectural register file, directly downstream of the MEM/WB pipeline register.
- Selects the writeback result from load data, ALU result or jump-link address, and commits it to a 32-entry register file.
- Serves the two combinational read ports used by the decode stage, with same-cycle write-through bypass.
- Keeps a committed-write counter for debug and performance monitoring.

Parameters:
DATA_W, 32, register and result width
REG_AW, 5, register address width (2**REG_AW registers)
PC_W, 5, width of the link address (PC+1) carried into WB
LINK_REG, 31, destination register forced for jump-and-link writes

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
reg_write_W  in  1  write enable from MEM/WB register
mem_to_reg_W  in  1  1 selects read_data_W, 0 selects alu_out_W
read_data_W  in  DATA_W  load data from MEM/WB register
alu_out_W  in  DATA_W  ALU result from MEM/WB register
write_reg_W  in  REG_AW  destination register
addressP1_WB  in  PC_W  PC+1 link value
jump_W  in  1  jump-and-link indicator
rs_addr_D  in  REG_AW  decode read port A address
rt_addr_D  in  REG_AW  decode read port B address
rs_data_D  out  DATA_W  read port A data (combinational)
rt_data_D  out  DATA_W  read port B data (combinational)
result_W  out  DATA_W  selected writeback value (combinational, forwarding source)
wb_dest_W  out  REG_AW  effective destination (combinational)
wb_en_W  out  1  effective write enable (combinational)
wb_count  out  32  committed-write counter (registered)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Result select, priority order:
  - jump_W=1 gives result_W = zero-extended addressP1_WB.
  - Otherwise mem_to_reg_W=1 gives read_data_W.
  - Otherwise alu_out_W.
- wb_dest_W = LINK_REG when jump_W=1, else write_reg_W.
- wb_en_W = reg_write_W & (wb_dest_W != 0) & !reset.
- Commit: at a rising edge with wb_en_W=1, regs[wb_dest_W] <= result_W. Latency is one edge from WB inputs to architectural state.
- Register 0 is hard-wired: never written, always reads 0, including through the bypass.
- Reads are combinational:
  - rs_data_D = 0 if rs_addr_D == 0.
  - Else result_W if (wb_en_W && rs_addr_D == wb_dest_W) (write-through bypass).
  - Else regs[rs_addr_D].
  - rt_data_D follows the identical rule using rt_addr_D.
- Both ports may read the same address, including the one being written; both see the bypassed value.
- wb_count increments by 1 on each edge where wb_en_W=1, and wraps 0xFFFFFFFF -> 0. Writes to r0 and writes with reg_write_W=0 do not count.
- Reset, sampled at a rising edge:
  - All registers 1..2**REG_AW-1 clear to 0; wb_count clears to 0.
  - Any write presented in the same cycle is discarded (wb_en_W=0), so no bypass.
  - Reset asserted mid-stream for one cycle clears state; the next edge after deassertion resumes normal commits.
- Reset values of outputs:
  - wb_count = 0.
  - With zero inputs after reset, rs_data_D, rt_data_D and result_W = 0, wb_dest_W = 0, wb_en_W = 0.
- Before the first reset, register contents are don't-care and are not checked.
- No stall or flush inputs: the upstream register inserts bubbles by driving reg_write_W=0.

Test Plan:
- Reset then read all 32 addresses on both ports -> all return 0; wb_count=0.
- ALU write: reg_write_W=1, mem_to_reg_W=0, alu_out_W=0x0000_1234, write_reg_W=8; rs_addr_D=8 same cycle -> rs_data_D=0x1234 via bypass; after edge, regs[8]=0x1234, wb_count=1.
- Load write: mem_to_reg_W=1, read_data_W=0xDEAD_BEEF, alu_out_W=0x5, write_reg_W=3 -> r3=0xDEADBEEF. A write with write_reg_W=0 of 0xFFFFFFFF -> r0 still reads 0 and wb_count is unchanged.
- Jump-link: jump_W=1, reg_write_W=1, addressP1_WB=5'd17, write_reg_W=4 -> r31=0x11, r4 untouched, result_W=0x11, wb_dest_W=31.
- Back-to-back writes to r9 (0xA then 0xB) while rt_addr_D=9:
  - rt_data_D=0xA in the first cycle and 0xB in the second.
  - Final r9=0xB; wb_count advances by 2.
- Reset collision and counter wrap:
  - Assert reset together with a valid write to r10=0x77 -> r10=0, wb_count=0.
  - Force wb_count to 0xFFFFFFFF via back-door deposit, then one commit -> wb_count=0.
